// File: rtl/shiftx_ift_pkg.sv
// Shared constants and window/taint helpers for the shiftx_ift pipeline.
package shiftx_ift_pkg;

    localparam int TAG_WIDTH    = 32;
    localparam int CONSERVATIVE = 0;
    localparam int PRECISE      = 1;

    typedef enum logic [1:0] {
        TAINT_ZERO,
        TAINT_A,
        TAINT_AB
    } taint_sel_e;

    function automatic logic src_in_range(input int pos, input int a_width);
        return (pos >= 0) && (pos < a_width);
    endfunction

    // A window that reads nothing from A cannot leak A's tag unless the shift itself is tainted.
    function automatic taint_sel_e taint_select(input int mode, input logic b_tainted,
                                                input logic any_in_range);
        if (mode == CONSERVATIVE || b_tainted) begin
            return TAINT_AB;
        end else if (any_in_range) begin
            return TAINT_A;
        end
        return TAINT_ZERO;
    endfunction

endpackage

// File: rtl/shiftx_ift_stage.sv
// One valid/ready register slice; accepts a new beat whenever it is empty or draining.
module shiftx_ift_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    // NOTE: the payload is reset too, because the outputs must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/shiftx_ift_pipe.sv
// Windowed shift with taint tracking, computed at the input and carried through STAGES register slices.
module shiftx_ift_pipe #(
    parameter int B_SIGNED  = 1,
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 4,
    parameter int Y_WIDTH   = 4,
    parameter int TAG_WIDTH = shiftx_ift_pkg::TAG_WIDTH,
    parameter int STAGES    = 2,
    parameter int PRECISE   = shiftx_ift_pkg::PRECISE,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [TAG_WIDTH-1:0] A_t,
    input  logic [B_WIDTH-1:0]   B,
    input  logic [TAG_WIDTH-1:0] B_t,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Y_WIDTH-1:0]   Y,
    output logic [TAG_WIDTH-1:0] Y_t,
    input  logic                 taint_clr,
    output logic [CNT_WIDTH-1:0] taint_cnt
);

    localparam int PW     = Y_WIDTH + TAG_WIDTH;
    localparam int AIDX_W = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;

    int                   shift;
    int                   pos;
    logic                 any_hit;
    logic [Y_WIDTH-1:0]   y_c;
    logic [TAG_WIDTH-1:0] y_t_c;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        shift   = (B_SIGNED != 0) ? int'($signed(B)) : int'(B);
        pos     = 0;
        any_hit = 1'b0;
        y_c     = '0;
        y_t_c   = '0;
        for (int i = 0; i < Y_WIDTH; i++) begin
            pos = shift + i;
            if (shiftx_ift_pkg::src_in_range(pos, A_WIDTH)) begin
                y_c[i]  = A[pos[AIDX_W-1:0]];
                any_hit = 1'b1;
            end
        end
        case (shiftx_ift_pkg::taint_select(PRECISE, |B_t, any_hit))
            shiftx_ift_pkg::TAINT_AB: y_t_c = A_t | B_t;
            shiftx_ift_pkg::TAINT_A:  y_t_c = A_t;
            default:                  y_t_c = '0;
        endcase
    end

    logic [STAGES:0] valid_c;
    logic [STAGES:0] ready_c;
    logic [PW-1:0]   data_c [0:STAGES];

    assign valid_c[0]      = in_valid;
    assign data_c[0]       = {y_c, y_t_c};
    assign in_ready        = ready_c[0];
    assign ready_c[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        shiftx_ift_stage #(
            .W(PW)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .in_valid_i  (valid_c[k]),
            .in_ready_o  (ready_c[k]),
            .in_data_i   (data_c[k]),
            .out_valid_o (valid_c[k+1]),
            .out_ready_i (ready_c[k+1]),
            .out_data_o  (data_c[k+1])
        );
    end

    assign out_valid = valid_c[STAGES];
    assign {Y, Y_t}  = data_c[STAGES];

    logic [CNT_WIDTH-1:0] taint_cnt_q;
    logic [CNT_WIDTH-1:0] taint_cnt_d;

    always_comb begin
        taint_cnt_d = taint_cnt_q;
        if (taint_clr) begin
            taint_cnt_d = '0;
        end else if (out_valid && out_ready && (|Y_t) && (taint_cnt_q != '1)) begin
            taint_cnt_d = taint_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taint_cnt_q <= '0;
        end else begin
            taint_cnt_q <= taint_cnt_d;
        end
    end

    assign taint_cnt = taint_cnt_q;

endmodule

// File: tb/tb_shiftx_ift_pipe.sv
// Bench for shiftx_ift_pipe: directed vectors, backpressure/saturation/reset sequences and a random scoreboard run.
module tb_shiftx_ift_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A = '0;
    logic [31:0] A_t = '0;
    logic [3:0]  B = '0;
    logic [31:0] B_t = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  Y;
    logic [31:0] Y_t;
    logic        taint_clr = 1'b0;
    logic [15:0] taint_cnt;

    shiftx_ift_pipe #(
        .B_SIGNED(1), .A_WIDTH(8), .B_WIDTH(4), .Y_WIDTH(4),
        .TAG_WIDTH(32), .STAGES(2), .PRECISE(1), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .A_t(A_t), .B(B), .B_t(B_t),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .Y_t(Y_t),
        .taint_clr(taint_clr), .taint_cnt(taint_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  y;
        logic [31:0] yt;
    } beat_t;

    typedef struct {
        logic [7:0]  a;
        logic [3:0]  b;
        logic [31:0] at;
        logic [31:0] bt;
        logic [3:0]  y;
        logic [31:0] yt;
    } vec_t;

    beat_t       exp_q[$];
    vec_t        vecs[8];
    logic [15:0] cnt_m = '0;
    bit          sb_on = 1'b1;
    bit          hold_pend = 1'b0;
    logic [3:0]  hold_y;
    logic [31:0] hold_yt;
    bit          last_in_hs = 1'b0;
    int          n_pop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: place A in a zero-padded field and shift the window down arithmetically.
    function automatic logic [3:0] ref_y(input logic [7:0] a, input logic [3:0] b);
        int     sh;
        longint v;
        sh = int'($signed(b));
        v  = longint'(a) << 16;
        return 4'((v >> (16 + sh)) & 64'hF);
    endfunction

    function automatic logic [31:0] ref_t(input logic [3:0] b, input logic [31:0] at,
                                          input logic [31:0] bt);
        int sh;
        sh = int'($signed(b));
        if (bt != 0) return at | bt;
        if ((sh + 4 > 0) && (sh < 8)) return at;
        return 32'h0;
    endfunction

    // Observe one clock cycle at the falling edge, update the model, then advance past the rising edge.
    task automatic step();
        beat_t e;
        bit    in_hs;
        bit    out_hs;
        @(negedge clk);
        in_hs  = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        if (hold_pend) begin
            check("hold_valid", out_valid, 1);
            check("hold_y", Y, hold_y);
            check("hold_yt", Y_t, hold_yt);
        end
        hold_pend = out_valid && !out_ready;
        hold_y    = Y;
        hold_yt   = Y_t;
        e.y  = '0;
        e.yt = '0;
        if (out_hs) begin
            check("sb_beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_pop++;
                if (sb_on) begin
                    check("sb_y", Y, e.y);
                    check("sb_yt", Y_t, e.yt);
                end
            end
        end
        if (taint_clr) cnt_m = '0;
        else if (out_hs && e.yt != 0 && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        if (in_hs) exp_q.push_back('{ref_y(A, B), ref_t(B, A_t, B_t)});
        if (rst) begin
            exp_q.delete();
            cnt_m     = '0;
            hold_pend = 1'b0;
        end
        last_in_hs = in_hs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          tbl_cnt;
        int          sent;
        int          n0;
        bit          low_seen;
        bit          ghost;

        vecs[0] = '{8'hA5, 4'h2, 32'h1, 32'h0, 4'h9, 32'h1};
        vecs[1] = '{8'hA5, 4'hF, 32'h0, 32'h0, 4'hA, 32'h0};
        vecs[2] = '{8'hA5, 4'h7, 32'h0, 32'h0, 4'h1, 32'h0};
        vecs[3] = '{8'hFF, 4'h8, 32'h4, 32'h0, 4'h0, 32'h0};
        vecs[4] = '{8'hFF, 4'h8, 32'h4, 32'h2, 4'h0, 32'h6};
        vecs[5] = '{8'hFF, 4'hC, 32'h8, 32'h0, 4'h0, 32'h0};
        vecs[6] = '{8'hFF, 4'hD, 32'h8, 32'h0, 4'h8, 32'h8};
        vecs[7] = '{8'h3C, 4'h4, 32'h0, 32'h10, 4'h3, 32'h10};

        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_y", Y, 0);
        check("rst_yt", Y_t, 0);
        check("rst_cnt", taint_cnt, 0);

        tbl_cnt   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            A = vecs[i].a; B = vecs[i].b; A_t = vecs[i].at; B_t = vecs[i].bt;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            check("vec_out_valid", out_valid, 1);
            check("vec_y", Y, vecs[i].y);
            check("vec_yt", Y_t, vecs[i].yt);
            if (vecs[i].yt != 0) tbl_cnt++;
            step();
            check("vec_cnt", taint_cnt, tbl_cnt);
        end

        sent     = 0;
        n0       = n_pop;
        low_seen = 1'b0;
        for (int c = 1; c <= 20 && (n_pop - n0) < 6; c++) begin
            in_valid = (sent < 6);
            A   = 8'h5A ^ 8'(sent * 37);
            B   = 4'(sent + 13);
            A_t = 32'(sent);
            B_t = 32'h0;
            out_ready = !(c >= 3 && c <= 5);
            #1;
            if (!in_ready) low_seen = 1'b1;
            step();
            if (last_in_hs) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_in_ready_low", low_seen, 1);
        check("bp_beats_in", sent, 6);
        check("bp_beats_out", n_pop - n0, 6);

        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_on = 1'b0;
        A = 8'hFF; B = 4'h0; A_t = 32'h1; B_t = 32'h0;
        in_valid = 1'b1;
        sent = 0;
        for (int c = 0; c < 70000 && sent < 65535; c++) begin
            step();
            if (last_in_hs) sent++;
        end
        in_valid = 1'b0;
        repeat (4) step();
        sb_on = 1'b1;
        check("sat_preload", taint_cnt, 16'hFFFF);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("sat_hold", taint_cnt, 16'hFFFF);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("clr_beat_ready", out_valid, 1);
        taint_clr = 1'b1;
        step();
        taint_clr = 1'b0;
        check("clr_wins", taint_cnt, 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 8'hFF; B = 4'h0; A_t = 32'h1;
        step();
        A = 8'h0F;
        step();
        check("rst_mid_two_inflight", exp_q.size(), 2);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_y", Y, 0);
        check("rst_mid_yt", Y_t, 0);
        check("rst_mid_in_ready", in_ready, 1);
        out_ready = 1'b1;
        ghost = 1'b0;
        repeat (4) begin
            step();
            if (out_valid) ghost = 1'b1;
        end
        check("rst_mid_no_ghost", ghost, 0);

        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            A   = 8'($urandom);
            B   = 4'($urandom);
            A_t = ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom);
            B_t = ($urandom_range(0, 2) != 0) ? 32'h0 : 32'($urandom);
            taint_clr = ($urandom_range(0, 31) == 0);
            step();
            check("rand_cnt", taint_cnt, cnt_m);
        end
        taint_clr = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
